// File: rtl/pool_pkg.sv
// Shared constants and types for the 2x2 max-pooling stage after layer_0.
package pool_pkg;

  localparam int DATA_W = 18;   // post-ReLU feature value width
  localparam int N_OUT  = 169;  // 13x13 pooled entries per channel
  localparam int ADDR_W = 8;    // pooled buffer address width
  localparam int BEATS  = 4;    // TL, TR, BL, BR

  typedef logic [1:0] beat_t;

endpackage

// File: rtl/ram.sv
// Simple dual-port buffer: synchronous write, combinational read.
// The read data is registered (and reset) by the instantiating module.
module ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port is combinational so a same-edge write is seen only on the next read
  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_0.sv
// 2x2 max-pooling of the layer_0 window stream into a 13x13 buffer per channel.
module pool_0 #(
  parameter int DATA_W = 18,
  parameter int N_OUT  = 169,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_done,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] din_0,
  input  logic [DATA_W-1:0] din_1,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dout_0,
  output logic [DATA_W-1:0] dout_1,
  output logic [ADDR_W-1:0] cnt,
  output logic              bsy,
  output logic              done,
  output logic              err
);

  import pool_pkg::*;

  localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);

  beat_t             beat_q, beat_d;
  logic [DATA_W-1:0] max0_q, max0_d, max1_q, max1_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              we;
  logic [DATA_W-1:0] run0, run1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [DATA_W-1:0] dout0_q, dout1_q;

  // Running per-channel maximum including the current beat (unsigned compare)
  always_comb begin
    run0 = (din_0 > max0_q) ? din_0 : max0_q;
    run1 = (din_1 > max1_q) ? din_1 : max1_q;
  end

  // Next-state: tx_done beats any coincident beat; beats after done only flag err
  always_comb begin
    beat_d = beat_q;
    max0_d = max0_q;
    max1_d = max1_q;
    ptr_d  = ptr_q;
    done_d = done_q;
    err_d  = err_q;
    we     = 1'b0;
    if (tx_done) begin
      beat_d = '0;
      max0_d = '0;
      max1_d = '0;
      ptr_d  = '0;
      done_d = 1'b0;
      err_d  = 1'b0;
    end else if (in_vld) begin
      if (done_q) begin
        err_d = 1'b1;
      end else if (beat_q == LAST_BEAT) begin
        we     = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        done_d = (ptr_d == ADDR_W'(N_OUT));
        beat_d = '0;
      end else begin
        max0_d = (beat_q == '0) ? din_0 : run0;
        max1_d = (beat_q == '0) ? din_1 : run1;
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // Per-image state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      max0_q <= '0;
      max1_q <= '0;
      ptr_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      max0_q <= max0_d;
      max1_q <= max1_d;
      ptr_q  <= ptr_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  ram #(
    .ADDR_WIDTH(ADDR_W),
    .DATA_WIDTH(DATA_W)
  ) u_ram_0 (
    .clk  (clk),
    .we   (we),
    .waddr(ptr_q),
    .wdata(run0),
    .raddr(rd_addr),
    .rdata(rdata0)
  );

  ram #(
    .ADDR_WIDTH(ADDR_W),
    .DATA_WIDTH(DATA_W)
  ) u_ram_1 (
    .clk  (clk),
    .we   (we),
    .waddr(ptr_q),
    .wdata(run1),
    .raddr(rd_addr),
    .rdata(rdata1)
  );

  // Registered read data with reset, one cycle after rd_addr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      dout0_q <= rdata0;
      dout1_q <= rdata1;
    end
  end

  assign dout_0 = dout0_q;
  assign dout_1 = dout1_q;
  assign cnt    = ptr_q;
  assign bsy    = (beat_q != '0);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: doc/pool_0.md
# pool_0

2x2 max-pooling stage directly downstream of the first convolution layer (`layer_0`). It consumes the 4-beat window stream read from `layer_0`'s two 26x26 feature-map RAMs and reduces each window to its maximum per channel. It stores the 13x13 pooled maps, 169 entries per channel, in an internal buffer. The next layer reads the buffer by address, gated by a write count.

## Interface
Parameters:
- DATA_W, 18, feature-map value width (unsigned, post-ReLU)
- N_OUT, 169, pooled entries per channel per image
- ADDR_W, 8, buffer address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_done  in  1  end-of-image; synchronous clear of all per-image state
- in_vld  in  1  one window beat present on din_0/din_1
- din_0  in  DATA_W  channel-0 beat value
- din_1  in  DATA_W  channel-1 beat value
- rd_addr  in  ADDR_W  downstream read address, 0..168
- dout_0  out  DATA_W  channel-0 pooled value, registered
- dout_1  out  DATA_W  channel-1 pooled value, registered
- cnt  out  ADDR_W  number of pooled entries written this image; rd_addr < cnt is valid
- bsy  out  1  a window is partially accumulated
- done  out  1  all N_OUT entries written
- err  out  1  sticky; in_vld received while done

## Operation
- Top level drives in_vld one cycle after each `layer_0` window address (RAM read latency). Beats arrive in order TL, TR, BL, BR; gaps between beats are legal.
- beat counter 0..3:
  - beat 0 loads max_0/max_1 with din.
  - beats 1-2 update max_x with max(max_x, din_x), compared unsigned.
- Beat 3:
  - writes max(max_x, din_x) to buffer[wr_ptr] for both channels at the same edge.
  - wr_ptr increments, then the beat counter returns to 0.
- cnt = wr_ptr.
- done rises at the edge where wr_ptr reaches N_OUT.
- Once done is high, in_vld is ignored: no write, no counter change, err set.
- bsy = (beat counter != 0).
- Read path: dout_x <= buffer_x[rd_addr] every cycle.
  - Reading the address being written in the same cycle returns the old data.
  - rd_addr >= N_OUT returns undefined data; downstream must not issue it.
- tx_done (highest priority, over a coincident in_vld) clears:
  - beat counter, max regs, wr_ptr, done, err.
  - Buffer contents are not cleared.
  - A partial window is discarded.
- No arithmetic overflow: max is width-preserving DATA_W.

## Timing
- Reset values:
  - dout_0 = dout_1 = 0, cnt = 0, bsy = 0, done = 0, err = 0.
  - Beat counter = 0, max regs = 0.
- Write latency: the entry is in the buffer and cnt has incremented at the edge that samples the 4th beat. Downstream may read it on the next cycle.
- Read latency: 1 cycle from rd_addr to dout.
- done and the final cnt = 169 update together on the 169th window's last beat.
- Reset asserted mid-window: immediate clear. Behaviour after deassertion is identical to power-up.
- Back-to-back windows, i.e. a beat 0 on the cycle after a beat 3, are supported at full rate. Minimum throughput is 4 cycles per entry.

## Structure
- Package `pool_pkg`: DATA_W, N_OUT, ADDR_W, BEATS = 4 constants; beat counter typedef `beat_t` (logic [1:0]).
- Buffer: two instances of the existing `ram` module (ADDR_WIDTH = 8, DATA_WIDTH = 18), sharing write enable, write address and read address.
- dout reset is handled in `pool_0`'s own output register, not in `ram`.
- Max/compare logic and beat counter stay in `pool_0`; no further sub-modules.

## Test plan
- Single window, beats ch0 = 5, 9, 3, 7 and ch1 = 0, 0, 0x3FFFF, 1:
  - cnt 0->1 on beat 4.
  - rd_addr = 0 gives dout_0 = 9 and dout_1 = 0x3FFFF one cycle later.
- 169 back-to-back windows, entry k = {k, k+1, k+2, k+3}:
  - done rises with cnt = 169.
  - Every address reads k+3.
  - A 170th in_vld sets err; cnt stays 169.
- Gapped beats, with in_vld low 3 cycles between each beat:
  - Result is identical to the gap-free run.
  - bsy is high from beat 1 until beat 3 is sampled.
- tx_done after beat 2 of window 5:
  - cnt = 0, bsy = 0, done = 0, err = 0.
  - The next 4 beats produce entry 0 from the new beats only.
- tx_done coincident with a beat-3 in_vld: no write, cnt = 0.
- rst_n pulse mid-window: all outputs are 0 asynchronously; a subsequent full window writes entry 0 correctly.
